// File: rtl/shift_add_mul4_if.sv
// shift_add_mul4_if: start/operand/result bundle for the shift-add multiplier
interface shift_add_mul4_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mul4.sv
// shift_add_mul4: 4x4 unsigned shift-add multiplier, 4 CALC cycles; MUL_ZERO_SKIP_EN enables zero-operand shortcut
module shift_add_mul4 (
  input  logic             clk,
  input  logic             rst_n,
  shift_add_mul4_if.slave  mul_s
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [8:0] work_q, work_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic [4:0] sum;
  logic [8:0] step;
  logic       accept;
  logic       zero_op;
  assign accept  = (state_q != CALC) && mul_s.start;
  assign zero_op = (mul_s.a == 4'd0) || (mul_s.b == 4'd0);
  // One shift-add step; the carry bit is always zero on entry because the previous shift filled it with 0
  always_comb begin
    sum  = {work_q[8], work_q[7:4]} + (work_q[0] ? {1'b0, mcand_q} : 5'd0);
    step = {1'b0, sum, work_q[3:1]};
  end
  // Next-state: accept in IDLE/DONE, iterate in CALC, load product after the fourth step
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (accept) begin
      mcand_d = mul_s.a;
      work_d  = {5'd0, mul_s.b};
      cnt_d   = 2'd0;
`ifdef MUL_ZERO_SKIP_EN
      state_d   = zero_op ? DONE : CALC;
      product_d = zero_op ? 8'h00 : product_q;
`else
      state_d = CALC;
`endif
    end else if (state_q == CALC) begin
      work_d    = step;
      cnt_d     = cnt_q + 2'd1;
      state_d   = (cnt_q == 2'd3) ? DONE : CALC;
      product_d = (cnt_q == 2'd3) ? step[7:0] : product_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= 4'd0;
      work_q    <= 9'd0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
`ifndef MUL_ZERO_SKIP_EN
  logic unused_zero;
  assign unused_zero = zero_op;
`endif
  assign mul_s.busy    = state_q == CALC;
  assign mul_s.done    = state_q == DONE;
  assign mul_s.product = product_q;
endmodule

// File: tb/tb_shift_add_mul4.sv
// tb_shift_add_mul4: randomized and directed checks of shift_add_mul4 against a plain a*b timing model
module tb_shift_add_mul4;
`ifdef MUL_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  logic [7:0] prev = 8'h00;
  shift_add_mul4_if bus ();
  shift_add_mul4 dut (.clk(clk), .rst_n(rst_n), .mul_s(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic b, input logic d, input logic [7:0] p);
    chk({tag, "_busy"}, {7'd0, bus.busy}, {7'd0, b});
    chk({tag, "_done"}, {7'd0, bus.done}, {7'd0, d});
    chk({tag, "_product"}, bus.product, p);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mul(input logic [3:0] x, input logic [3:0] y);
    int lat;
    logic [7:0] exp;
    lat = (ZSKIP && (x == 4'd0 || y == 4'd0)) ? 0 : 4;
    exp = 8'(int'(x) * int'(y));
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    tick();
    for (int k = 0; k < lat; k++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.a = 4'($urandom);
      bus.b = 4'($urandom);
      outs("calc", 1'b1, 1'b0, prev);
      tick();
    end
    bus.start = 1'b0;
    outs("done", 1'b0, 1'b1, exp);
    prev = exp;
    tick();
    outs("idle", 1'b0, 1'b0, prev);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.a = 4'd0;
    bus.b = 4'd0;
    #1;
    outs("reset", 1'b0, 1'b0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    outs("post_reset", 1'b0, 1'b0, 8'h00);
    mul(4'd3, 4'd4);
    mul(4'd15, 4'd15);
    mul(4'd9, 4'd4);
    mul(4'd0, 4'd9);
    bus.start = 1'b1;
    bus.a = 4'd2;
    bus.b = 4'd5;
    tick();
    bus.a = 4'd7;
    bus.b = 4'd7;
    for (int k = 0; k < 4; k++) begin
      outs("ignore_calc", 1'b1, 1'b0, prev);
      tick();
    end
    bus.start = 1'b0;
    outs("ignore_done", 1'b0, 1'b1, 8'h0A);
    prev = 8'h0A;
    tick();
    outs("ignore_idle", 1'b0, 1'b0, prev);
    bus.start = 1'b1;
    bus.a = 4'd10;
    bus.b = 4'd5;
    tick();
    bus.start = 1'b0;
    tick();
    outs("abort_calc", 1'b1, 1'b0, prev);
    rst_n = 1'b0;
    #1;
    outs("abort_async", 1'b0, 1'b0, 8'h00);
    prev = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      outs("abort_hold", 1'b0, 1'b0, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    mul(4'd10, 4'd5);
    bus.start = 1'b1;
    bus.a = 4'd1;
    bus.b = 4'd1;
    tick();
    for (int n = 0; n < 15; n++) begin
      outs("b2b", n % 5 != 4, n % 5 == 4, n >= 4 ? 8'h01 : prev);
      if (n == 14) bus.start = 1'b0;
      tick();
    end
    prev = 8'h01;
    outs("b2b_idle", 1'b0, 1'b0, prev);
    for (int i = 0; i < 24; i++) begin
      mul(4'($urandom), (i % 6 == 0) ? 4'd0 : 4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/shift_add_mul4.md
SHIFT_ADD_MUL4 -- requirements
Module: shift_add_mul4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to multiply a by b; sampled on the rising edge of clk.
REQ-005 a  input  4  unsigned multiplicand; sampled only on the edge where start is accepted.
REQ-006 b  input  4  unsigned multiplier; sampled only on the edge where start is accepted.
REQ-007 busy  output  1  high while a multiplication is in progress (state CALC).
REQ-008 done  output  1  one-cycle pulse; the product is valid from this cycle on.
REQ-009 product  output  8  registered unsigned result a*b; holds the last completed result.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 start SHALL be accepted only when busy=0 (state IDLE or DONE), on the edge E0 where start=1.
REQ-012 On acceptance, the block SHALL capture a into a 4-bit multiplicand register and b into the low half of the work register.
- Work register: 9 bits {c, acc[3:0], mq[3:0]}, with acc=0, c=0, mq=b.
- FSM moves to CALC with a 2-bit iteration count of 0.
REQ-013 Each CALC cycle SHALL perform one shift-add step:
- if mq[0]=1: {c,acc} = acc + multiplicand (4-bit add with carry-out); else {c,acc} = {0,acc}.
- Then {c,acc,mq} SHALL shift right by one with 0 entering the MSB.
- The iteration count then increments.
REQ-014 After the fourth CALC step (edge E4), product SHALL load {acc,mq} and the FSM SHALL enter DONE.
- Latency: done is high in the cycle after E4, i.e. 4 clocks after the accepting edge.
REQ-015 DONE SHALL last exactly one cycle, then return to IDLE unless start=1 at that edge, which is accepted per REQ-011.
REQ-016 start=1 while busy=1 SHALL be ignored, with no effect on state, operands or product.
REQ-017 product SHALL change only on completion (REQ-014) or reset, and SHALL hold its old value throughout CALC.
REQ-018 a and b changing during CALC SHALL have no effect on the result in progress.
REQ-019 Arithmetic SHALL be unsigned and exact for all 256 operand pairs, with no overflow possible (max 15*15=225=8'hE1).

Reset
REQ-020 rst_n=0 SHALL immediately, without waiting for clk, force:
- FSM to IDLE;
- busy=0, done=0, product=8'h00;
- work register, multiplicand and iteration count to 0.
REQ-021 Reset asserted mid-CALC SHALL abort the operation, with no done pulse and product=8'h00.
REQ-022 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-023 Macro MUL_ZERO_SKIP_EN, when defined, SHALL enable the zero shortcut: if a=0 or b=0 at the accepting edge, the block SHALL go directly to DONE.
- product=8'h00 and done high 1 clock after the accepting edge.
- busy never asserts.
REQ-024 Without MUL_ZERO_SKIP_EN, zero operands SHALL take the full 4-cycle CALC path and produce product=8'h00 with REQ-014 latency.

Verification
REQ-025 a=3, b=4, start pulsed 1 cycle -> busy high 4 cycles, done pulse 4 clocks after the accepting edge, product=8'h0C.
REQ-026 a=15, b=15 -> product=8'hE1 (carry path exercised); follow with a=9, b=4 -> 8'h24, previous 8'hE1 held until the second done.
REQ-027 Start a=2, b=5; re-pulse start with a=7, b=7 during CALC -> request ignored, product=8'h0A, single done pulse.
REQ-028 Start a=10, b=5; assert rst_n=0 at the second CALC cycle -> outputs 0 immediately, no done; after release, a=10, b=5 -> 8'h32.
REQ-029 a=0, b=9 -> product=8'h00 with done 1 clock after the accepting edge with MUL_ZERO_SKIP_EN, or 4 clocks without it.
REQ-030 start held high continuously with a=1, b=1 -> back-to-back operations, each accepted in its DONE cycle, done every 5 clocks, product=8'h01.
